// File: rtl/scalar_wb_arbiter.sv
// rtl/scalar_wb_arbiter.sv - writeback arbiter between ALU results and a load-result FIFO
module scalar_wb_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [WIDTH-1:0]         alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [WIDTH-1:0]         mem_data,
  input  logic                     issue_load,
  input  logic [4:0]               issue_rd,
  output logic [4:0]               RD,
  output logic [255:0]             WD,
  output logic                     WES,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Load-result storage and pointers
  logic [4:0]       fifo_rd_q   [DEPTH];
  logic [4:0]       fifo_rd_d   [DEPTH];
  logic [WIDTH-1:0] fifo_data_q [DEPTH];
  logic [WIDTH-1:0] fifo_data_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Outstanding-load scoreboard and registered writeback port
  logic [31:0]      pending_q, pending_d;
  logic             wes_q, wes_d;
  logic [4:0]       rd_q, rd_d;
  logic [255:0]     wd_q, wd_d;

  // Arbitration decisions for this cycle
  logic             fifo_full;
  logic             fifo_empty;
  logic             enq;
  logic             head_commit;
  logic             alu_commit;
  logic [4:0]       head_rd;
  logic [WIDTH-1:0] head_data;

  // Full FIFO forces the head out so loads can never be starved by a busy ALU;
  // otherwise the ALU has priority and the FIFO drains in idle ALU cycles.
  always_comb begin
    fifo_full   = (count_q == FULL_CNT);
    fifo_empty  = (count_q == '0);
    mem_ready   = !fifo_full;
    alu_ready   = !fifo_full;
    enq         = mem_valid && !fifo_full;
    head_commit = fifo_full || (!alu_valid && !fifo_empty);
    alu_commit  = !fifo_full && alu_valid;
    head_rd     = fifo_rd_q[rd_ptr_q];
    head_data   = fifo_data_q[rd_ptr_q];
  end

  // FIFO storage write, pointer advance and occupancy update
  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (enq) begin
      fifo_rd_d[wr_ptr_q]   = mem_rd;
      fifo_data_d[wr_ptr_q] = mem_data;
      wr_ptr_d              = wr_ptr_q + PTR_ONE;
    end
    if (head_commit) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({enq, head_commit})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pending scoreboard: clear on load commit, then set on issue so a same-register set wins
  always_comb begin
    pending_d = pending_q;
    if (head_commit) begin
      pending_d[head_rd] = 1'b0;
    end
    if (issue_load) begin
      pending_d[issue_rd] = 1'b1;
    end
  end

  // Writeback port: winner data is left-justified in the 256-bit bus, RD/WD hold when idle
  always_comb begin
    wes_d = head_commit || alu_commit;
    rd_d  = rd_q;
    wd_d  = wd_q;
    if (head_commit) begin
      rd_d             = head_rd;
      wd_d             = '0;
      wd_d[255-:WIDTH] = head_data;
    end else if (alu_commit) begin
      rd_d             = alu_rd;
      wd_d             = '0;
      wd_d[255-:WIDTH] = alu_data;
    end
  end

  // State registers; reset discards any queued load results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      wes_q     <= 1'b0;
      rd_q      <= '0;
      wd_q      <= '0;
    end else begin
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      wes_q       <= wes_d;
      rd_q        <= rd_d;
      wd_q        <= wd_d;
    end
  end

  assign RD         = rd_q;
  assign WD         = wd_q;
  assign WES        = wes_q;
  assign pending    = pending_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// tb/tb_scalar_wb_arbiter.sv - self-checking bench for scalar_wb_arbiter
module tb_scalar_wb_arbiter;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         alu_valid;
  logic         alu_ready;
  logic [4:0]   alu_rd;
  logic [15:0]  alu_data;
  logic         mem_valid;
  logic         mem_ready;
  logic [4:0]   mem_rd;
  logic [15:0]  mem_data;
  logic         issue_load;
  logic [4:0]   issue_rd;
  logic [4:0]   RD;
  logic [255:0] WD;
  logic         WES;
  logic [31:0]  pending;
  logic [2:0]   fifo_count;

  scalar_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_load(issue_load), .issue_rd(issue_rd),
    .RD(RD), .WD(WD), .WES(WES), .pending(pending), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [15:0] data;
  } ent_t;

  // Reference model: queue of accepted loads plus expected writeback state
  ent_t         mq[$];
  logic         m_wes;
  logic [4:0]   m_rd;
  logic [255:0] m_wd;
  logic [31:0]  m_pend;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    logic room;
    room = (mq.size() < DEPTH);
    chk("alu_ready", alu_ready, room);
    chk("mem_ready", mem_ready, room);
    chk("fifo_count", fifo_count, mq.size());
    chk("pending", pending, m_pend);
    chk("WES", WES, m_wes);
    chk("RD", RD, m_rd);
    chk("WD", WD, m_wd);
  endtask

  // Check the current cycle, advance the model by one edge, then wait for that edge
  task automatic tick();
    logic        full;
    logic        commit;
    logic [4:0]  wrd;
    logic [15:0] wdat;
    ent_t        h;
    ent_t        e;
    #1;
    check_all();
    full   = (mq.size() == DEPTH);
    commit = 1'b0;
    wrd    = '0;
    wdat   = '0;
    if (full || (!alu_valid && mq.size() > 0)) begin
      h      = mq.pop_front();
      commit = 1'b1;
      wrd    = h.rd;
      wdat   = h.data;
      m_pend[h.rd] = 1'b0;
    end else if (alu_valid) begin
      commit = 1'b1;
      wrd    = alu_rd;
      wdat   = alu_data;
    end
    if (mem_valid && !full) begin
      e.rd   = mem_rd;
      e.data = mem_data;
      mq.push_back(e);
    end
    if (issue_load) m_pend[issue_rd] = 1'b1;
    m_wes = commit;
    if (commit) begin
      m_rd = wrd;
      m_wd = {wdat, 240'h0};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid  = 1'b0;
    alu_rd     = '0;
    alu_data   = '0;
    mem_valid  = 1'b0;
    mem_rd     = '0;
    mem_data   = '0;
    issue_load = 1'b0;
    issue_rd   = '0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    mq.delete();
    m_wes  = 1'b0;
    m_rd   = '0;
    m_wd   = '0;
    m_pend = '0;
    #1;
    check_all();
    chk("rst_wes_async", WES, 1'b0);
    chk("rst_count_async", fifo_count, 3'd0);
    chk("rst_pending_async", pending, 32'h0);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    reset_pulse();
    tick();

    // Single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 16'h1234;
    tick();
    alu_valid = 1'b0;
    chk("alu_wes", WES, 1'b1);
    chk("alu_rd", RD, 5'd5);
    chk("alu_wd", WD, {16'h1234, 240'h0});
    tick();
    chk("alu_wes_drop", WES, 1'b0);

    // Load path with pending tracking
    issue_load = 1'b1; issue_rd = 5'd7;
    tick();
    issue_load = 1'b0;
    chk("load_pend_set", pending[7], 1'b1);
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 16'hBEEF;
    tick();
    mem_valid = 1'b0;
    chk("load_queued", fifo_count, 3'd1);
    chk("load_no_wes_yet", WES, 1'b0);
    chk("load_pend_hold", pending[7], 1'b1);
    tick();
    chk("load_wes", WES, 1'b1);
    chk("load_rd", RD, 5'd7);
    chk("load_wd", WD, {16'hBEEF, 240'h0});
    chk("load_pend_clr", pending[7], 1'b0);
    tick();

    // Contention: ALU every cycle while four loads arrive back-to-back
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_rd   = 5'(20 + i);
      alu_data = 16'($urandom);
      mem_rd   = 5'(1 + i);
      mem_data = 16'(16'hA000 + i);
      tick();
    end
    chk("full_count", fifo_count, 3'd4);
    chk("full_mem_ready", mem_ready, 1'b0);
    chk("full_alu_ready", alu_ready, 1'b0);
    mem_rd = 5'd9; mem_data = 16'h9999;
    tick();
    chk("full_head_rd", RD, 5'd1);
    chk("full_head_wd", WD, {16'hA000, 240'h0});
    chk("full_no_enq", fifo_count, 3'd3);
    chk("alu_ready_back", alu_ready, 1'b1);
    mem_valid = 1'b0;
    tick();
    alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("drained", fifo_count, 3'd0);
    chk("last_load_rd", RD, 5'd4);

    // Same-edge set and clear on register 3
    issue_load = 1'b1; issue_rd = 5'd3;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 16'h0033;
    tick();
    mem_valid = 1'b0;
    tick();
    issue_load = 1'b0;
    chk("same_edge_wes", WES, 1'b1);
    chk("same_edge_rd", RD, 5'd3);
    chk("same_edge_pend", pending[3], 1'b1);
    tick();

    // Reset with three loads queued
    alu_valid = 1'b1; mem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_rd = 5'(i); alu_data = 16'(i);
      mem_rd = 5'(10 + i); mem_data = 16'(16'hC000 + i);
      issue_load = 1'b1; issue_rd = 5'(10 + i);
      tick();
    end
    chk("pre_rst_count", fifo_count, 3'd3);
    idle_inputs();
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_wes", WES, 1'b0);
    end

    // Register 0 is an ordinary destination
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 16'h00FF;
    tick();
    alu_valid = 1'b0;
    chk("r0_rd", RD, 5'd0);
    chk("r0_wd", WD, {16'h00FF, 240'h0});
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      alu_valid  = ($urandom_range(0, 99) < 45);
      alu_rd     = 5'($urandom);
      alu_data   = 16'($urandom);
      mem_valid  = ($urandom_range(0, 99) < 60);
      mem_rd     = 5'($urandom);
      mem_data   = 16'($urandom);
      issue_load = ($urandom_range(0, 99) < 30);
      issue_rd   = 5'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse();
      end else begin
        tick();
      end
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) tick();
    chk("final_empty", fifo_count, 3'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
